// File: rtl/tqvp_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tqvp_bus_pkg
// Description : Shared definitions for the TinyQV peripheral bus arbiter:
//               transfer-size encoding, FSM state encoding and the data word
//               returned on a read error.
// Revision    : 1.0 - initial release
// ============================================================================
package tqvp_bus_pkg;

    // Transfer size encoding used on write_n / read_n (11 = no transfer)
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_NONE = 2'b11;

    // Transaction FSM state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t c_ST_IDLE  = 2'd0;
    localparam arb_state_t c_ST_WRITE = 2'd1;
    localparam arb_state_t c_ST_READ  = 2'd2;
    localparam arb_state_t c_ST_DONE  = 2'd3;

    // Data returned to a requester whose read timed out
    localparam logic [31:0] c_ERR_DATA = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/tqvp_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tqvp_rr_arbiter2
// Description : Two-way round-robin grant. The grant is combinational from
//               the request vector; the last-grant register advances only
//               when the caller accepts the grant (i_en).
// Ports       : clk, rst        - clock, async active-high reset
//               i_req[1:0]      - request vector
//               i_en            - accept the current grant this cycle
//               o_valid         - at least one request present
//               o_idx           - index of the granted requester
//               o_last_grant    - index of the most recently accepted grant
// Revision    : 1.0 - initial release
// ============================================================================
module tqvp_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_valid,
    output logic       o_idx,
    output logic       o_last_grant
);

    logic r_last_grant;
    logic w_idx;

    always_comb begin
        w_idx = 1'b0;
        case (i_req)
            2'b01:   w_idx = 1'b0;
            2'b10:   w_idx = 1'b1;
            // Contention: favour whoever was not served last
            2'b11:   w_idx = ~r_last_grant;
            default: w_idx = 1'b0;
        endcase
    end

    // Reset to 1 so that requester 0 wins the very first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (i_en && (|i_req)) begin
            r_last_grant <= w_idx;
        end
    end

    assign o_valid      = |i_req;
    assign o_idx        = w_idx;
    assign o_last_grant = r_last_grant;

endmodule
`default_nettype wire

// File: rtl/tqvp_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tqvp_bus_arbiter
// Description : Shares one TinyQV peripheral register port between two
//               requesters (m0, m1). Round-robin grant, one transaction at a
//               time: writes strobe for one cycle, reads wait on
//               p_data_ready and abort with an error after TIMEOUT cycles.
//               Every output is registered.
// Ports       : clk, rst                  - clock, async active-high reset
//               mN_req/address/data_in    - requester N command (held to ack)
//               mN_write_n/read_n         - size, 00 byte/01 half/10 word/11 none
//               mN_ack/data_out/err       - one-cycle completion + result
//               p_*                       - peripheral register port
//               busy                      - FSM not in IDLE
//               last_grant                - most recently granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module tqvp_bus_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [31:0]       m0_data_in,
    input  logic [1:0]        m0_write_n,
    input  logic [1:0]        m0_read_n,
    output logic              m0_ack,
    output logic [31:0]       m0_data_out,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [31:0]       m1_data_in,
    input  logic [1:0]        m1_write_n,
    input  logic [1:0]        m1_read_n,
    output logic              m1_ack,
    output logic [31:0]       m1_data_out,
    output logic              m1_err,
    output logic [ADDR_W-1:0] p_address,
    output logic [31:0]       p_data_in,
    output logic [1:0]        p_data_write_n,
    output logic [1:0]        p_data_read_n,
    input  logic [31:0]       p_data_out,
    input  logic              p_data_ready,
    output logic              busy,
    output logic              last_grant
);

    import tqvp_bus_pkg::*;

    // FSM and transaction bookkeeping
    arb_state_t        r_state, w_next_state;
    logic [7:0]        r_cnt, w_cnt_next;
    logic              r_gnt, w_gnt_next;

    // Registered outputs and their next values
    logic [1:0]        r_ack, w_ack;
    logic [1:0]        r_err, w_err;
    logic [1:0][31:0]  r_dout, w_dout;
    logic [ADDR_W-1:0] r_p_addr, w_p_addr;
    logic [31:0]       r_p_din, w_p_din;
    logic [1:0]        r_p_wn, w_p_wn;
    logic [1:0]        r_p_rn, w_p_rn;
    logic              r_busy, w_busy;

    // Arbitration and selected-requester command
    logic              w_arb_valid, w_arb_idx, w_last_grant;
    logic              w_is_idle;
    logic              w_rd_timeout;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [1:0]        w_sel_wn, w_sel_rn;

    assign w_is_idle    = (r_state == c_ST_IDLE);
    assign w_rd_timeout = (r_cnt == 8'(TIMEOUT - 1));

    tqvp_rr_arbiter2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .i_req        ({m1_req, m0_req}),
        .i_en         (w_is_idle),
        .o_valid      (w_arb_valid),
        .o_idx        (w_arb_idx),
        .o_last_grant (w_last_grant)
    );

    assign w_sel_addr  = w_arb_idx ? m1_address : m0_address;
    assign w_sel_wdata = w_arb_idx ? m1_data_in : m0_data_in;
    assign w_sel_wn    = w_arb_idx ? m1_write_n : m0_write_n;
    assign w_sel_rn    = w_arb_idx ? m1_read_n  : m0_read_n;

    // ------------------------------------------------------------------
    // State register (plus all registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= 8'd0;
            r_gnt    <= 1'b0;
            r_ack    <= 2'b00;
            r_err    <= 2'b00;
            r_dout   <= '0;
            r_p_addr <= '0;
            r_p_din  <= 32'd0;
            r_p_wn   <= c_SZ_NONE;
            r_p_rn   <= c_SZ_NONE;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_cnt_next;
            r_gnt    <= w_gnt_next;
            r_ack    <= w_ack;
            r_err    <= w_err;
            r_dout   <= w_dout;
            r_p_addr <= w_p_addr;
            r_p_din  <= w_p_din;
            r_p_wn   <= w_p_wn;
            r_p_rn   <= w_p_rn;
            r_busy   <= w_busy;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_arb_valid) begin
                    if (w_sel_wn != c_SZ_NONE) begin
                        w_next_state = c_ST_WRITE;
                    end else if (w_sel_rn != c_SZ_NONE) begin
                        w_next_state = c_ST_READ;
                    end else begin
                        w_next_state = c_ST_DONE;
                    end
                end
            end
            c_ST_WRITE: w_next_state = c_ST_DONE;
            c_ST_READ: begin
                if (p_data_ready || w_rd_timeout) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs. Completion
    // results are loaded on the edge that enters DONE so that the ack is
    // visible exactly while the FSM sits in DONE.
    // ------------------------------------------------------------------
    always_comb begin
        w_ack      = 2'b00;
        w_err      = 2'b00;
        w_dout     = r_dout;
        w_p_addr   = r_p_addr;
        w_p_din    = r_p_din;
        w_p_wn     = c_SZ_NONE;
        w_p_rn     = c_SZ_NONE;
        w_gnt_next = r_gnt;
        w_cnt_next = 8'd0;
        w_busy     = (w_next_state != c_ST_IDLE);
        case (r_state)
            c_ST_IDLE: begin
                if (w_arb_valid) begin
                    w_gnt_next = w_arb_idx;
                    if (w_sel_wn != c_SZ_NONE) begin
                        w_p_addr = w_sel_addr;
                        w_p_din  = w_sel_wdata;
                        w_p_wn   = w_sel_wn;
                    end else if (w_sel_rn != c_SZ_NONE) begin
                        w_p_addr = w_sel_addr;
                        w_p_rn   = w_sel_rn;
                    end else begin
                        // Neither a read nor a write: complete at once with error
                        w_ack[w_arb_idx]  = 1'b1;
                        w_err[w_arb_idx]  = 1'b1;
                        w_dout[w_arb_idx] = 32'd0;
                    end
                end
            end
            c_ST_WRITE: begin
                w_ack[r_gnt] = 1'b1;
            end
            c_ST_READ: begin
                if (p_data_ready) begin
                    w_ack[r_gnt]  = 1'b1;
                    w_dout[r_gnt] = p_data_out;
                end else if (w_rd_timeout) begin
                    w_ack[r_gnt]  = 1'b1;
                    w_err[r_gnt]  = 1'b1;
                    w_dout[r_gnt] = c_ERR_DATA;
                end else begin
                    w_p_rn     = r_p_rn;
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign m0_ack         = r_ack[0];
    assign m1_ack         = r_ack[1];
    assign m0_err         = r_err[0];
    assign m1_err         = r_err[1];
    assign m0_data_out    = r_dout[0];
    assign m1_data_out    = r_dout[1];
    assign p_address      = r_p_addr;
    assign p_data_in      = r_p_din;
    assign p_data_write_n = r_p_wn;
    assign p_data_read_n  = r_p_rn;
    assign busy           = r_busy;
    assign last_grant     = w_last_grant;

endmodule
`default_nettype wire
